// File: rtl/hazard_stall_controller.sv
// Load-use stall and taken-branch flush sequencing for the five-stage pipeline.
// Also keeps saturating stall-cycle and flush-event counters for perf debug.
module hazard_stall_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IDR1,
    input  logic [4:0]       IDR2,
    input  logic             IDUsesR2,
    input  logic             IDEXMemRead,
    input  logic [4:0]       IDEXWriteReg,
    input  logic             BranchTaken,
    output logic             StallPC,
    output logic             StallIFID,
    output logic             BubbleIDEX,
    output logic             FlushIFID,
    output logic             FlushIDEX,
    output logic             FlushEXMEM,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushEvents
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t nextState;
    logic   hazard;
    logic   stallReq;
    logic   flushReq;
    logic   stallOut;
    logic   flushOut;

    always_comb begin
        hazard = IDEXMemRead && (IDEXWriteReg != 5'd0) &&
                 ((IDEXWriteReg == IDR1) ||
                  (IDUsesR2 && (IDEXWriteReg == IDR2)));
    end

    always_comb begin
        stallReq  = 1'b0;
        flushReq  = 1'b0;
        nextState = RUN;
        unique case (state)
            RUN: begin
                if (BranchTaken) begin
                    flushReq  = 1'b1;
                    nextState = FLUSH;
                end else if (hazard) begin
                    stallReq  = 1'b1;
                    nextState = STALL;
                end
            end
            STALL: begin
                if (BranchTaken) begin
                    flushReq  = 1'b1;
                    nextState = FLUSH;
                end
            end
            // The branch seen here belongs to a squashed instruction.
            FLUSH: nextState = RUN;
            default: nextState = RUN;
        endcase
    end

    assign stallOut = stallReq && rst_n;
    assign flushOut = flushReq && rst_n;

    assign StallPC    = stallOut;
    assign StallIFID  = stallOut;
    assign BubbleIDEX = stallOut;
    assign FlushIFID  = flushOut;
    assign FlushIDEX  = flushOut;
    assign FlushEXMEM = flushOut;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            StallCycles <= '0;
            FlushEvents <= '0;
        end else begin
            state <= nextState;
            if (stallOut && (StallCycles != '1)) begin
                StallCycles <= StallCycles + 1'b1;
            end
            if (flushOut && (FlushEvents != '1)) begin
                FlushEvents <= FlushEvents + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with 4-bit counters.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_hazard_stall_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       IDR1;
    logic [4:0]       IDR2;
    logic             IDUsesR2;
    logic             IDEXMemRead;
    logic [4:0]       IDEXWriteReg;
    logic             BranchTaken;
    logic             StallPC;
    logic             StallIFID;
    logic             BubbleIDEX;
    logic             FlushIFID;
    logic             FlushIDEX;
    logic             FlushEXMEM;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushEvents;

    int checks = 0;
    int failures = 0;

    hazard_stall_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .IDR1(IDR1),
        .IDR2(IDR2),
        .IDUsesR2(IDUsesR2),
        .IDEXMemRead(IDEXMemRead),
        .IDEXWriteReg(IDEXWriteReg),
        .BranchTaken(BranchTaken),
        .StallPC(StallPC),
        .StallIFID(StallIFID),
        .BubbleIDEX(BubbleIDEX),
        .FlushIFID(FlushIFID),
        .FlushIDEX(FlushIDEX),
        .FlushEXMEM(FlushEXMEM),
        .StallCycles(StallCycles),
        .FlushEvents(FlushEvents)
    );

    always #5 clk = ~clk;

    wire [2:0] stallV = {StallPC, StallIFID, BubbleIDEX};
    wire [2:0] flushV = {FlushIFID, FlushIDEX, FlushEXMEM};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                         input logic uses, input logic mr,
                         input logic [4:0] wr, input logic br);
        IDR1 = r1;
        IDR2 = r2;
        IDUsesR2 = uses;
        IDEXMemRead = mr;
        IDEXWriteReg = wr;
        BranchTaken = br;
    endtask

    task automatic doReset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1);
        #1;
        checks++;
        if ({stallV, flushV} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outs got=%b exp=000000", {stallV, flushV});
        end
        checks++;
        if ({StallCycles, FlushEvents} !== 8'h00) begin
            failures++;
            $display("FAIL reset_cnt got=%h exp=00", {StallCycles, FlushEvents});
        end
        step();
        step();
        #1;
        checks++;
        if ({stallV, flushV, StallCycles, FlushEvents} !== 14'b0) begin
            failures++;
            $display("FAIL reset_held got=%b exp=0",
                     {stallV, flushV, StallCycles, FlushEvents});
        end
        BranchTaken = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({stallV, flushV} !== 6'b111000) begin
            failures++;
            $display("FAIL reset_release got=%b exp=111000", {stallV, flushV});
        end
        step();
        #1;
        checks++;
        if (StallCycles !== 4'd1) begin
            failures++;
            $display("FAIL reset_first_cnt got=%0d exp=1", StallCycles);
        end
    endtask

    task automatic test_load_use_rs2();
        doReset();
        drive(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
        #1;
        checks++;
        if (stallV !== 3'b111) begin
            failures++;
            $display("FAIL rs2_stall got=%b exp=111", stallV);
        end
        step();
        #1;
        checks++;
        if ({stallV, flushV} !== 6'b0) begin
            failures++;
            $display("FAIL rs2_stall_cycle got=%b exp=000000", {stallV, flushV});
        end
        checks++;
        if (StallCycles !== 4'd1) begin
            failures++;
            $display("FAIL rs2_cnt got=%0d exp=1", StallCycles);
        end
        IDEXMemRead = 1'b0;
        step();
        drive(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0);
        #1;
        checks++;
        if (stallV !== 3'b000) begin
            failures++;
            $display("FAIL rs2_unused got=%b exp=000", stallV);
        end
        step();
        #1;
        checks++;
        if (StallCycles !== 4'd1) begin
            failures++;
            $display("FAIL rs2_unused_cnt got=%0d exp=1", StallCycles);
        end
    endtask

    task automatic test_rs1();
        doReset();
        drive(5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b0);
        #1;
        checks++;
        if (stallV !== 3'b111) begin
            failures++;
            $display("FAIL rs1_stall got=%b exp=111", stallV);
        end
        step();
        drive(5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b0);
        step();
        #1;
        checks++;
        if (stallV !== 3'b000) begin
            failures++;
            $display("FAIL rs1_noload got=%b exp=000", stallV);
        end
    endtask

    task automatic test_x0();
        doReset();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        #1;
        checks++;
        if (stallV !== 3'b000) begin
            failures++;
            $display("FAIL x0_stall got=%b exp=000", stallV);
        end
        step();
        #1;
        checks++;
        if (StallCycles !== 4'd0) begin
            failures++;
            $display("FAIL x0_cnt got=%0d exp=0", StallCycles);
        end
    endtask

    task automatic test_branch_flush();
        doReset();
        drive(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1);
        #1;
        checks++;
        if ({stallV, flushV} !== 6'b000111) begin
            failures++;
            $display("FAIL br_first got=%b exp=000111", {stallV, flushV});
        end
        step();
        #1;
        checks++;
        if ({stallV, flushV} !== 6'b0) begin
            failures++;
            $display("FAIL br_second got=%b exp=000000", {stallV, flushV});
        end
        checks++;
        if ({StallCycles, FlushEvents} !== {4'd0, 4'd1}) begin
            failures++;
            $display("FAIL br_cnt got=%h exp=01", {StallCycles, FlushEvents});
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        step();
        #1;
        checks++;
        if (FlushEvents !== 4'd1) begin
            failures++;
            $display("FAIL br_cnt_hold got=%0d exp=1", FlushEvents);
        end
    endtask

    task automatic test_branch_in_stall();
        doReset();
        drive(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
        step();
        BranchTaken = 1'b1;
        #1;
        checks++;
        if ({stallV, flushV} !== 6'b000111) begin
            failures++;
            $display("FAIL bs_flush got=%b exp=000111", {stallV, flushV});
        end
        step();
        #1;
        checks++;
        if ({stallV, flushV} !== 6'b0) begin
            failures++;
            $display("FAIL bs_flushstate got=%b exp=000000", {stallV, flushV});
        end
        checks++;
        if ({StallCycles, FlushEvents} !== {4'd1, 4'd1}) begin
            failures++;
            $display("FAIL bs_cnt got=%h exp=11", {StallCycles, FlushEvents});
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        drive(5'd7, 5'd4, 1'b1, 1'b1, 5'd4, 1'b0);
        step();
        drive(5'd7, 5'd4, 1'b1, 1'b1, 5'd7, 1'b0);
        #1;
        checks++;
        if (stallV !== 3'b000) begin
            failures++;
            $display("FAIL b2b_stall_cycle got=%b exp=000", stallV);
        end
        step();
        #1;
        checks++;
        if (stallV !== 3'b111) begin
            failures++;
            $display("FAIL b2b_second got=%b exp=111", stallV);
        end
        step();
        #1;
        checks++;
        if (StallCycles !== 4'd2) begin
            failures++;
            $display("FAIL b2b_cnt got=%0d exp=2", StallCycles);
        end
    endtask

    task automatic test_saturation();
        doReset();
        drive(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
        for (int i = 0; i < 40; i++) step();
        #1;
        checks++;
        if (StallCycles !== 4'd15) begin
            failures++;
            $display("FAIL sat_cnt got=%0d exp=15", StallCycles);
        end
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stallV, StallCycles, FlushEvents} !== 11'b0) begin
            failures++;
            $display("FAIL mid_reset got=%b exp=0",
                     {stallV, StallCycles, FlushEvents});
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (stallV !== 3'b111) begin
            failures++;
            $display("FAIL mid_reset_release got=%b exp=111", stallV);
        end
        step();
        #1;
        checks++;
        if (StallCycles !== 4'd1) begin
            failures++;
            $display("FAIL mid_reset_cnt got=%0d exp=1", StallCycles);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        test_reset();
        test_load_use_rs2();
        test_rs1();
        test_x0();
        test_branch_flush();
        test_branch_in_stall();
        test_back_to_back();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Central hazard controller for the 64-bit five-stage pipeline, sitting alongside the decode stage and directly upstream of the ID/EX pipeline register. Detects load-use hazards between the instruction in ID and the load in EX, and sequences the stall and bubble. Also sequences the three-stage flush when a branch resolves taken in MEM. Keeps saturating stall and flush event counters for performance debug.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  pipeline clock, rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- IDR1  in  5  rs1 field of the instruction in ID
- IDR2  in  5  rs2 field of the instruction in ID
- IDUsesR2  in  1  ID instruction reads rs2 (R-type, store, branch)
- IDEXMemRead  in  1  instruction in EX is a load
- IDEXWriteReg  in  5  destination register of the instruction in EX
- BranchTaken  in  1  branch in MEM resolved taken (Branch/BranchGeq condition true)
- StallPC  out  1  hold PC this cycle
- StallIFID  out  1  hold IF/ID this cycle
- BubbleIDEX  out  1  ID/EX loads all-zero control fields this cycle
- FlushIFID, FlushIDEX, FlushEXMEM  out  1 each  zero the control fields of that register at the next edge
- StallCycles  out  CNT_W  saturating count of cycles with StallPC=1
- FlushEvents  out  CNT_W  saturating count of accepted taken branches

## Operation
- Hazard term: H = IDEXMemRead & (IDEXWriteReg != 0) & ((IDEXWriteReg == IDR1) | (IDUsesR2 & IDEXWriteReg == IDR2)). Register x0 never causes a hazard.
- FSM states: RUN, STALL, FLUSH. The state register resets to RUN.
- RUN behaviour:
  - If BranchTaken: assert FlushIFID, FlushIDEX and FlushEXMEM; keep all stall outputs at 0; go to FLUSH. Flush has priority over H.
  - Else if H: assert StallPC, StallIFID and BubbleIDEX; go to STALL.
  - Else: all outputs 0; stay in RUN.
- STALL behaviour:
  - Stall outputs are forced to 0, even if H is still true. Exactly one stall cycle is inserted per load-use.
  - If BranchTaken: assert the three flushes and go to FLUSH. Otherwise go to RUN.
- FLUSH behaviour:
  - The instructions now in IF/ID and ID/EX are squashed, so stall and flush outputs are forced to 0.
  - BranchTaken is ignored here, because it comes from a squashed instruction.
  - Always go to RUN.
- Output logic: all control outputs are combinational from the current state and the inputs, and are gated to 0 while rst_n=0.
- Counters:
  - StallCycles increments by 1 at each clock edge where StallPC=1.
  - FlushEvents increments by 1 at each edge where the flushes are asserted.
  - Both counters hold at 2^CNT_W-1 (saturate, never wrap).

## Timing
- Reset: rst_n low asynchronously sets state=RUN and both counters to 0. All control outputs read 0 for as long as rst_n is low, including a reset asserted mid-STALL or mid-FLUSH. The first active edge after release evaluates from RUN.
- Stall latency: 0 cycles. StallPC, StallIFID and BubbleIDEX are valid in the same cycle H is presented and act at that cycle's rising edge.
- Load-use penalty: exactly 1 cycle. The next cycle is STALL with outputs 0, and the dependent instruction enters EX one cycle after the load leaves EX.
- Flush latency: 0 cycles. The flushes act at the edge ending the cycle in which BranchTaken=1. The following cycle (FLUSH) generates no stall.
- Back-to-back:
  - H in the cycle right after STALL (new load/use pair) is honoured only from RUN. The STALL→RUN→STALL sequence is legal.
  - Two consecutive loads feeding the same consumer produce one stall per load.
- Simultaneous events:
  - BranchTaken and H in RUN: flush only; StallCycles unchanged; FlushEvents +1.
- Counter updates are registered and visible one cycle after the event.

## Test plan
- Reset: hold rst_n=0 with H and BranchTaken both true → every output is 0, state is RUN and both counters are 0. Release rst_n → outputs respond from the first cycle.
- Load-use on rs2:
  - Stimulus: IDEXMemRead=1, IDEXWriteReg=5, IDR1=3, IDR2=5, IDUsesR2=1.
  - Response: StallPC, StallIFID and BubbleIDEX are 1 for exactly one cycle and then 0 while the inputs are held. StallCycles=1 afterwards.
  - Repeat with IDUsesR2=0 → no stall.
- x0 immunity: IDEXMemRead=1, IDEXWriteReg=0, IDR1=0 → no stall and StallCycles stays at 0.
- Branch flush:
  - Stimulus: BranchTaken=1 for 2 consecutive cycles in RUN.
  - Response: the three flushes assert for the first cycle only, and FlushEvents=1.
  - Also drive H=1 in that same first cycle → no stall.
- Branch during STALL: trigger a load-use, then assert BranchTaken in the STALL cycle → flushes assert, the next cycle is FLUSH with outputs 0, StallCycles=1 and FlushEvents=1.
- Saturation and mid-operation reset:
  - With CNT_W=4, create 20 stall events → StallCycles reads 15.
  - Assert rst_n=0 while in STALL → counters read 0 and there is no residual stall after release.
